// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file sizing and writeback requester IDs
package regfile_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = 5;

    localparam int WB_ALU    = 0;
    localparam int WB_LOAD   = 1;
    localparam int WB_MULDIV = 2;
    localparam int WB_NREQ   = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered pointer, one-hot and binary grant
module rr_arbiter #(
    parameter int  N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW:0]   idx;
    logic          found;

    // Walk N slots starting at ptr; the extra idx bit absorbs ptr+k before the wrap.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (!found && req[idx[IW-1:0]]) begin
                found                 = 1'b1;
                grant[idx[IW-1:0]]    = 1'b1;
                grant_idx             = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback port arbiter for the register file; REGFILE_WB_PRIO0_EN gives the ALU strict priority
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int  WIDTH = REG_WIDTH,
    parameter int  DEPTH = REG_DEPTH,
    parameter int  NREQ  = WB_NREQ,
    localparam int AW    = $clog2(DEPTH),
    localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_wa,
    input  logic [NREQ*WIDTH-1:0] req_wd,
    output logic                  WE,
    output logic [AW-1:0]         WA,
    output logic [WIDTH-1:0]      WD,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
);

    logic [NREQ-1:0]  grant;
    logic [GW-1:0]    gidx;
    logic [AW-1:0]    sel_wa;
    logic [WIDTH-1:0] sel_wd;
    logic             transfer;

`ifdef REGFILE_WB_PRIO0_EN
    localparam int SN = NREQ - 1;
    localparam int SW = (SN > 1) ? $clog2(SN) : 1;

    logic [SN-1:0] sub_grant;
    logic [SW-1:0] sub_idx;

    // The ALU bypasses the rotation, so its grants leave the pointer untouched.
    rr_arbiter #(.N(SN)) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid[NREQ-1:1]),
        .advance   (~req_valid[WB_ALU]),
        .grant     (sub_grant),
        .grant_idx (sub_idx)
    );

    always_comb begin
        grant = '0;
        gidx  = '0;
        if (req_valid[WB_ALU]) begin
            grant[WB_ALU] = 1'b1;
            gidx          = GW'(WB_ALU);
        end else begin
            grant = {sub_grant, 1'b0};
            gidx  = GW'(sub_idx) + GW'(1);
        end
    end
`else
    rr_arbiter #(.N(NREQ)) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid),
        .advance   (1'b1),
        .grant     (grant),
        .grant_idx (gidx)
    );
`endif

    assign req_ready = grant & {NREQ{~reset}};
    assign transfer  = |req_ready;
    assign busy      = |req_valid;

    always_comb begin
        sel_wa = '0;
        sel_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_wa = req_wa[i*AW +: AW];
                sel_wd = req_wd[i*WIDTH +: WIDTH];
            end
        end
    end

    // Writes to register 0 still update WA/WD/grant_id but never pulse WE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            WE       <= 1'b0;
            WA       <= '0;
            WD       <= '0;
            grant_id <= '0;
        end else begin
            WE <= transfer && (sel_wa != '0);
            if (transfer) begin
                WA       <= sel_wa;
                WD       <= sel_wd;
                grant_id <= gidx;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clock;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_wa;
    logic [95:0] req_wd;
    logic        WE;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic [1:0]  grant_id;
    logic        busy;

    logic [31:0] ram [32];
    int          checks;
    int          errors;

    regfile_wb_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wa    (req_wa),
        .req_wd    (req_wd),
        .WE        (WE),
        .WA        (WA),
        .WD        (WD),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register-file model fed from the arbiter's write port.
    always @(posedge clock) begin
        if (WE) ram[WA] <= WD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] wa, input logic [31:0] wd);
        req_wa[i*5 +: 5]   = wa;
        req_wd[i*32 +: 32] = wd;
    endtask

    // Called just after a falling edge: drive valid, check ready, cross one rising edge, check outputs.
    task automatic cyc(input string tag, input logic [2:0] v, input logic [2:0] er,
                       input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                       input logic [1:0] egid);
        req_valid = v;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(er));
        check({tag, "_busy"}, 32'(busy), 32'(v != 3'b000));
        @(negedge clock);
        check({tag, "_we"}, 32'(WE), 32'(ewe));
        check({tag, "_wa"}, 32'(WA), 32'(ewa));
        check({tag, "_wd"}, WD, ewd);
        check({tag, "_gid"}, 32'(grant_id), 32'(egid));
    endtask

    logic [2:0] cont_v [6] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b110, 3'b100};

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) ram[i] = 32'h0;
        reset     = 1'b1;
        req_valid = 3'b111;
        req_wa    = '0;
        req_wd    = '0;
        for (int i = 0; i < 3; i++) set_req(i, 5'(10 + i), 32'(100 + i));

        // Reset held with all requesters valid.
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("rst_we", 32'(WE), 32'h0);
            check("rst_wa", 32'(WA), 32'h0);
            check("rst_wd", WD, 32'h0);
            check("rst_gid", 32'(grant_id), 32'h0);
            check("rst_ready", 32'(req_ready), 32'h0);
        end
        reset = 1'b0;

        // Contention: order 0,1,2,0,1,2; each requester drops after its second transfer.
        for (int c = 0; c < 6; c++) begin
            cyc($sformatf("cont%0d", c), cont_v[c], 3'(1 << (c % 3)), 1'b1,
                5'(10 + c % 3), 32'(100 + c % 3), 2'(c % 3));
        end
        cyc("idle0", 3'b000, 3'b000, 1'b0, 5'd12, 32'd102, 2'd2);

        // Single requester, pointer at 0.
        set_req(1, 5'd5, 32'hDEADBEEF);
        cyc("single", 3'b010, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
        cyc("single_idle", 3'b000, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1);
        check("single_ram5", ram[5], 32'hDEADBEEF);

        // Register 0 write, pointer at 2.
        set_req(2, 5'd0, 32'h1234);
        cyc("reg0", 3'b100, 3'b100, 1'b0, 5'd0, 32'h1234, 2'd2);
        cyc("reg0_idle", 3'b000, 3'b000, 1'b0, 5'd0, 32'h1234, 2'd2);
        check("reg0_ram0", ram[0], 32'h0);

        // Same address from requesters 0 and 1, pointer at 0.
        set_req(0, 5'd7, 32'hA);
        set_req(1, 5'd7, 32'hB);
        cyc("same0", 3'b011, 3'b001, 1'b1, 5'd7, 32'hA, 2'd0);
        cyc("same1", 3'b010, 3'b010, 1'b1, 5'd7, 32'hB, 2'd1);
        cyc("same_idle", 3'b000, 3'b000, 1'b0, 5'd7, 32'hB, 2'd1);
        check("same_ram7", ram[7], 32'hB);

        // Reset mid-stream with pointer moved to 1.
        set_req(0, 5'd1, 32'h11);
        set_req(1, 5'd2, 32'h22);
        set_req(2, 5'd3, 32'h33);
        cyc("mid0", 3'b111, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2);
        cyc("mid1", 3'b011, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0);
        req_valid = 3'b010;
        reset     = 1'b1;
        #1;
        check("midrst_we", 32'(WE), 32'h0);
        check("midrst_wa", 32'(WA), 32'h0);
        check("midrst_ready", 32'(req_ready), 32'h0);
        @(negedge clock);
        check("midrst_hold_we", 32'(WE), 32'h0);
        reset = 1'b0;
        cyc("after_rst", 3'b011, 3'b001, 1'b1, 5'd1, 32'h11, 2'd0);
        cyc("after_rst2", 3'b010, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1);
        cyc("final_idle", 3'b000, 3'b000, 1'b0, 5'd2, 32'h22, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
